multicycle_controller: RTL and testbench

- Parametrised multi-cycle sequencer for the 9-bit TinyChip ISA; owns the PC, instruction register (IR) and the branch/skip decision.
- Drives the external register file, ALU and data memory through explicit strobes.
- Differs from the single-edge controller in four ways:
  - configurable data, PC and memory-address widths;
  - real FETCH/EXEC/MEM/WB sequencing;
  - variable-latency memory handshake with timeout;
  - working beq/bne, jump and halt.

---
 rtl/multicycle_controller.sv | 250 +++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/EXEC/MEM/WB sequencer for the 9-bit TinyChip ISA.
// Owns the PC, the instruction register and the branch/skip decision, and
// drives the external register file, ALU and data memory through strobes.
module multicycle_controller #(
  parameter int DW          = 16,
  parameter int PC_W        = 8,
  parameter int AW          = 6,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [8:0]      instr,
  input  logic            eof,
  output logic [PC_W-1:0] pc,
  output logic [1:0]      rf_raddr1,
  output logic [1:0]      rf_raddr2,
  input  logic [DW-1:0]   rf_rdata1,
  input  logic [DW-1:0]   rf_rdata2,
  output logic            rf_we,
  output logic [1:0]      rf_waddr,
  output logic [DW-1:0]   rf_wdata,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [2:0]      alu_op,
  input  logic [DW-1:0]   alu_y,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ack,
  output logic            done,
  output logic            err
);

  localparam int              TCW     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TCW-1:0]  TC_LAST = TCW'(MEM_TIMEOUT - 1);
  localparam logic [TCW-1:0]  TC_ONE  = TCW'(1);
  localparam logic [TCW-1:0]  TC_ZERO = TCW'(0);
  localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);
  localparam logic [PC_W-1:0] PC_TWO  = PC_W'(2);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC  = 3'd1,
    S_MEM   = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t            r_state,     w_state_nxt;
  logic [PC_W-1:0]   r_pc,        w_pc_nxt;
  logic [8:0]        r_ir,        w_ir_nxt;
  logic [DW-1:0]     r_result,    w_result_nxt;
  logic              r_rf_we,     w_rf_we_nxt;
  logic              r_mem_req,   w_mem_req_nxt;
  logic              r_mem_we,    w_mem_we_nxt;
  logic [AW-1:0]     r_mem_addr,  w_mem_addr_nxt;
  logic [DW-1:0]     r_mem_wdata, w_mem_wdata_nxt;
  logic              r_done,      w_done_nxt;
  logic              r_err,       w_err_nxt;
  logic [TCW-1:0]    r_tcnt,      w_tcnt_nxt;

  // Instruction field decode from the latched IR.
  logic              w_bt;
  logic [2:0]        w_op;
  logic              w_fn;
  logic [DW-1:0]     w_imm;
  logic              w_eq;
  logic              w_take;

  assign w_bt   = r_ir[8];
  assign w_op   = r_ir[7:5];
  assign w_fn   = r_ir[0];
  assign w_imm  = {{(DW-3){1'b0}}, r_ir[2:0]};
  // beq (op 010) skips on equal, bne (op 011) skips on not-equal.
  assign w_eq   = (rf_rdata1 == w_imm);
  assign w_take = w_op[0] ? ~w_eq : w_eq;

  // Operand routing: immediate class uses imm as the second ALU operand.
  assign rf_raddr1 = r_ir[4:3];
  assign rf_raddr2 = r_ir[2:1];
  assign alu_op    = w_op;
  assign alu_a     = rf_rdata1;
  assign alu_b     = w_bt ? w_imm : rf_rdata2;

  assign pc        = r_pc;
  assign rf_we     = r_rf_we;
  assign rf_waddr  = r_ir[4:3];
  assign rf_wdata  = r_result;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign done      = r_done;
  assign err       = r_err;

  // Next-state and next-register computation for the sequencer.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_ir_nxt        = r_ir;
    w_result_nxt    = r_result;
    w_rf_we_nxt     = 1'b0;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_done_nxt      = r_done;
    w_err_nxt       = r_err;
    w_tcnt_nxt      = r_tcnt;
    case (r_state)
      S_FETCH: begin
        if (eof) begin
          w_state_nxt = S_HALT;
          w_done_nxt  = 1'b1;
        end else begin
          w_ir_nxt    = instr;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_bt) begin
          case (w_op)
            3'b010, 3'b011: begin
              w_pc_nxt    = r_pc + (w_take ? PC_TWO : PC_ONE);
              w_state_nxt = S_FETCH;
            end
            3'b100: begin
              w_mem_req_nxt   = 1'b1;
              w_mem_we_nxt    = 1'b0;
              w_mem_addr_nxt  = rf_rdata2[AW-1:0];
              w_mem_wdata_nxt = rf_rdata2;
              w_tcnt_nxt      = TC_ZERO;
              w_state_nxt     = S_MEM;
            end
            3'b101: begin
              w_mem_req_nxt   = 1'b1;
              w_mem_we_nxt    = 1'b1;
              w_mem_addr_nxt  = rf_rdata1[AW-1:0];
              w_mem_wdata_nxt = rf_rdata2;
              w_tcnt_nxt      = TC_ZERO;
              w_state_nxt     = S_MEM;
            end
            3'b110: begin
              w_result_nxt = rf_rdata1 >> r_ir[2:0];
              w_rf_we_nxt  = 1'b1;
              w_state_nxt  = S_WB;
            end
            3'b111: begin
              w_result_nxt = rf_rdata1 << r_ir[2:0];
              w_rf_we_nxt  = 1'b1;
              w_state_nxt  = S_WB;
            end
            default: begin
              w_result_nxt = alu_y;
              w_rf_we_nxt  = 1'b1;
              w_state_nxt  = S_WB;
            end
          endcase
        end else if (w_fn && (w_op == 3'b000)) begin
          w_pc_nxt    = rf_rdata2[PC_W-1:0];
          w_state_nxt = S_FETCH;
        end else if (w_fn && (w_op == 3'b101)) begin
          w_result_nxt = {DW{1'b0}};
          w_rf_we_nxt  = 1'b1;
          w_state_nxt  = S_WB;
        end else begin
          w_result_nxt = alu_y;
          w_rf_we_nxt  = 1'b1;
          w_state_nxt  = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          w_mem_req_nxt = 1'b0;
          w_tcnt_nxt    = TC_ZERO;
          if (r_mem_we) begin
            w_pc_nxt    = r_pc + PC_ONE;
            w_state_nxt = S_FETCH;
          end else begin
            w_result_nxt = mem_rdata;
            w_rf_we_nxt  = 1'b1;
            w_state_nxt  = S_WB;
          end
        end else if (r_tcnt == TC_LAST) begin
          // Memory never answered: stop the machine rather than guess.
          w_mem_req_nxt = 1'b0;
          w_tcnt_nxt    = TC_ZERO;
          w_err_nxt     = 1'b1;
          w_done_nxt    = 1'b1;
          w_state_nxt   = S_HALT;
        end else begin
          w_tcnt_nxt = r_tcnt + TC_ONE;
        end
      end
      S_WB: begin
        w_pc_nxt    = r_pc + PC_ONE;
        w_state_nxt = S_FETCH;
      end
      S_HALT: begin
        w_mem_req_nxt = 1'b0;
        w_state_nxt   = S_HALT;
      end
      default: begin
        w_mem_req_nxt = 1'b0;
        w_state_nxt   = S_FETCH;
      end
    endcase
  end

  // State register; reset returns the sequencer to FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and strobe registers; async reset kills any in-flight strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc        <= {PC_W{1'b0}};
      r_ir        <= 9'd0;
      r_result    <= {DW{1'b0}};
      r_rf_we     <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= {AW{1'b0}};
      r_mem_wdata <= {DW{1'b0}};
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_tcnt      <= TC_ZERO;
    end else begin
      r_pc        <= w_pc_nxt;
      r_ir        <= w_ir_nxt;
      r_result    <= w_result_nxt;
      r_rf_we     <= w_rf_we_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_tcnt      <= w_tcnt_nxt;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: the bench plays instruction memory,
// register file, ALU and data memory, and predicts each instruction's effect
// from the ISA rules (next pc, register write, memory access, cycle count).
module tb_multicycle_controller;

  localparam int DW = 16;
  localparam int PC_W = 8;
  localparam int AW = 6;
  localparam int MEM_TIMEOUT = 15;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [8:0]      instr;
  logic            eof;
  logic [PC_W-1:0] pc;
  logic [1:0]      rf_raddr1, rf_raddr2, rf_waddr;
  logic [DW-1:0]   rf_rdata1, rf_rdata2, rf_wdata;
  logic            rf_we;
  logic [DW-1:0]   alu_a, alu_b, alu_y;
  logic [2:0]      alu_op;
  logic            mem_req, mem_we, mem_ack;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;
  logic            done, err;

  logic [8:0]      prog [0:255];
  logic [DW-1:0]   regs [0:3];
  logic [DW-1:0]   dmem [0:63];
  logic            eof_en;
  logic [7:0]      eof_pc;

  int n_checks = 0;
  int n_errs = 0;
  int mpc = 0;

  multicycle_controller #(.DW(DW), .PC_W(PC_W), .AW(AW), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset(rst_n), .instr(instr), .eof(eof), .pc(pc),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Bench ALU: any fixed function per op works, the model uses the same table.
  function automatic logic [DW-1:0] alu_f(input logic [2:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    case (op)
      3'd0:    alu_f = a + b;
      3'd1:    alu_f = a - b;
      3'd2:    alu_f = a & b;
      3'd3:    alu_f = a | b;
      3'd4:    alu_f = a ^ b;
      3'd5:    alu_f = ~a;
      3'd6:    alu_f = a + b + DW'(1);
      default: alu_f = (a << 1) ^ b;
    endcase
  endfunction

  assign instr     = prog[pc];
  assign eof       = eof_en && (pc == eof_pc);
  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];
  assign alu_y     = alu_f(alu_op, alu_a, alu_b);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (pc model %0h)", tag, got, exp, mpc);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ack = 1'b0;
    eof_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mpc = 0;
  endtask

  // Execute one instruction at the model pc; d = cycles until mem_ack.
  task automatic run_instr(input int d);
    logic [8:0]    ins;
    logic          bt, fn;
    logic [2:0]    op;
    logic [1:0]    rd, ro;
    logic [DW-1:0] a, b, imm, exp_wdata, exp_mwdata, got_wd;
    logic [1:0]    got_wa;
    int            t, exp_npc, exp_maddr, wr_cnt, wr_cyc, mcnt, mbad;
    bit            exp_wr, exp_mem, exp_mwe;
    ins = prog[mpc];
    bt = ins[8]; op = ins[7:5]; rd = ins[4:3]; ro = ins[2:1]; fn = ins[0];
    a = regs[rd]; b = regs[ro]; imm = DW'(ins[2:0]);
    exp_npc = (mpc + 1) % 256; exp_wr = 0; exp_mem = 0; exp_mwe = 0;
    exp_wdata = '0; exp_mwdata = '0; exp_maddr = 0; t = 3;
    if (bt && (op == 3'd2 || op == 3'd3)) begin
      t = 2;
      if ((a == imm) == (op == 3'd2)) exp_npc = (mpc + 2) % 256;
    end else if (bt && op == 3'd4) begin
      exp_mem = 1; exp_maddr = int'(b) % 64; exp_wr = 1; exp_wdata = dmem[exp_maddr]; t = 3 + d;
    end else if (bt && op == 3'd5) begin
      exp_mem = 1; exp_mwe = 1; exp_maddr = int'(a) % 64; exp_mwdata = b; t = 2 + d;
    end else if (bt && op == 3'd6) begin
      exp_wr = 1; exp_wdata = a >> ins[2:0];
    end else if (bt && op == 3'd7) begin
      exp_wr = 1; exp_wdata = a << ins[2:0];
    end else if (bt) begin
      exp_wr = 1; exp_wdata = alu_f(op, a, imm);
    end else if (fn && op == 3'd0) begin
      t = 2; exp_npc = int'(b) % 256;
    end else if (fn && op == 3'd5) begin
      exp_wr = 1; exp_wdata = '0;
    end else begin
      exp_wr = 1; exp_wdata = alu_f(op, a, b);
    end
    check_eq("pc_start", 32'(pc), 32'(mpc));
    wr_cnt = 0; wr_cyc = -1; mcnt = 0; mbad = 0; got_wa = '0; got_wd = '0;
    for (int c = 1; c <= t; c++) begin
      @(posedge clk);
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = DW'($urandom);
      if (c == t - 1) check_eq("pc_hold", 32'(pc), 32'(mpc));
      if (rf_we) begin
        wr_cnt++; wr_cyc = c; got_wa = rf_waddr; got_wd = rf_wdata;
      end
      if (mem_req) begin
        mcnt++;
        if (mem_we !== exp_mwe || mem_addr !== AW'(exp_maddr) || (exp_mwe && mem_wdata !== exp_mwdata))
          mbad++;
        if (mcnt == d) begin
          mem_ack = 1'b1;
          mem_rdata = dmem[mem_addr];
        end
      end else if ($urandom_range(0, 3) == 0) begin
        mem_ack = 1'b1;
      end
    end
    check_eq("pc_next", 32'(pc), 32'(exp_npc));
    check_eq("wr_count", 32'(wr_cnt), exp_wr ? 32'd1 : 32'd0);
    if (exp_wr) begin
      check_eq("wr_addr", 32'(got_wa), 32'(rd));
      check_eq("wr_data", 32'(got_wd), 32'(exp_wdata));
      check_eq("wr_cycle", 32'(wr_cyc), 32'(t - 1));
    end
    check_eq("mem_cycles", 32'(mcnt), exp_mem ? 32'(d) : 32'd0);
    check_eq("mem_fields", 32'(mbad), 32'd0);
    if (exp_wr) regs[rd] = exp_wdata;
    if (exp_mem && exp_mwe) dmem[exp_maddr] = exp_mwdata;
    mpc = exp_npc;
  endtask

  initial begin
    int mreq_cnt, done_cyc, we_cnt;
    mem_rdata = '0;
    for (int i = 0; i < 256; i++) prog[i] = 9'($urandom);
    for (int i = 0; i < 64; i++) dmem[i] = DW'($urandom);
    do_reset();
    check_eq("rst_pc", 32'(pc), 32'd0);
    check_eq("rst_rf_we", 32'(rf_we), 32'd0);
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_ir", {27'd0, rf_waddr, alu_op}, 32'd0);

    // Directed: addi r1,#5; jump r2; beq r0,#0 (taken); beq r3,#0 (not taken); lw r1,[r2].
    regs[0] = 16'd0; regs[1] = 16'd3; regs[2] = 16'd4; regs[3] = 16'd1;
    prog[0] = 9'h10D; prog[1] = 9'h005; prog[4] = 9'h140; prog[6] = 9'h158; prog[7] = 9'h18C;
    for (int i = 0; i < 4; i++) run_instr(1);
    regs[2] = 16'h002A; dmem[42] = 16'hBEEF;
    run_instr(4);

    // Random instruction stream against the ISA model.
    for (int i = 0; i < 300; i++) run_instr($urandom_range(1, 6));

    // Reset while a store is waiting in MEM.
    prog[0] = 9'h1A2;
    do_reset();
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    check_eq("mid_mreq", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("async_mreq", 32'(mem_req), 32'd0);
    check_eq("async_pc", 32'(pc), 32'd0);
    check_eq("async_we", 32'(rf_we), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mpc = 0;
    run_instr(2);

    // Store that never completes: timeout halts the machine.
    do_reset();
    mreq_cnt = 0; done_cyc = -1; we_cnt = 0;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk);
      @(negedge clk);
      mem_ack = (c >= 20) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (mem_req) mreq_cnt++;
      if (rf_we) we_cnt++;
      if (done && done_cyc < 0) done_cyc = c;
    end
    check_eq("to_mreq_cycles", 32'(mreq_cnt), 32'(MEM_TIMEOUT));
    check_eq("to_done_cycle", 32'(done_cyc), 32'(MEM_TIMEOUT + 2));
    check_eq("to_err", 32'(err), 32'd1);
    check_eq("to_done", 32'(done), 32'd1);
    check_eq("to_mem_req", 32'(mem_req), 32'd0);
    check_eq("to_pc", 32'(pc), 32'd0);
    check_eq("to_we", 32'(we_cnt), 32'd0);

    // Jump to 0xFF, skip wraps to 1, jump to 0x1F3 truncates to 0xF3, eof halts.
    do_reset();
    regs[0] = 16'd0; regs[2] = 16'h01FF; regs[3] = 16'h01F3;
    prog[0] = 9'h005; prog[255] = 9'h140; prog[1] = 9'h007;
    for (int i = 0; i < 3; i++) run_instr(1);
    check_eq("jump_pc", 32'(pc), 32'h0F3);
    eof_en = 1'b1;
    eof_pc = 8'hF3;
    @(posedge clk);
    @(negedge clk);
    check_eq("eof_done", 32'(done), 32'd1);
    check_eq("eof_err", 32'(err), 32'd0);
    for (int c = 0; c < 5; c++) begin
      mem_ack = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      check_eq("halt_state", {28'd0, done, mem_req, rf_we, err}, 32'h8);
      check_eq("halt_pc", 32'(pc), 32'h0F3);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
